// File: rtl/uart_port_sequencer.sv
// uart_port_sequencer: arbitrates clear / RX read / TX write commands onto one UART port, one ISSUE+GAP slot each.
// Optional build macro UART_SEQ_ERR_LOCK_EN: a sampled uart_err locks out TX and reads until a clear slot completes.
module uart_port_sequencer #(
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned CW       = 4
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          req0_valid,
    input  logic [7:0]    req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [7:0]    req1_data,
    output logic          req1_ready,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    input  logic          clr_req,
    output logic          clr_done,
    input  logic [1:0]    rate_sel,
    input  logic          credit_ret,
    input  logic          uart_err,
    output logic [3:0]    ctrl,
    output logic [7:0]    tx_data,
    input  logic [7:0]    rx_data,
    output logic [CW-1:0] credits
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_TX   = 2'b01,
        CMD_RD   = 2'b10,
        CMD_CLR  = 2'b11
    } cmd_t;

    localparam logic [CW-1:0] CREDIT_MAX = CW'(TX_DEPTH);

    state_t        state;
    state_t        stateNext;
    cmd_t          cmdReg;
    cmd_t          cmdSel;
    logic          grantReg;
    logic          grantSel;
    logic          rrPtr;
    logic          txGrant;
    logic          clrEnd;
    logic          lockOut;
    logic          rdEligible;
    logic          txEligible;
    logic [7:0]    txDataReg;
    logic [7:0]    rdDataReg;
    logic          rdValidReg;
    logic [1:0]    rateReg;
    logic [CW-1:0] creditReg;

`ifdef UART_SEQ_ERR_LOCK_EN
    logic errLock;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            errLock <= 1'b0;
        end else if (clrEnd) begin
            errLock <= 1'b0;
        end else if (state == ST_IDLE && uart_err) begin
            errLock <= 1'b1;
        end
    end

    // The error blocks selection in the same IDLE cycle it is first seen.
    assign lockOut = errLock || (state == ST_IDLE && uart_err);
`else
    logic unusedErr;

    assign unusedErr = uart_err;
    assign lockOut   = 1'b0;
`endif

    // A read whose data is being returned this cycle is already served; the
    // requester only drops rd_req after seeing rd_valid.
    assign rdEligible = rd_req && !rdValidReg && !lockOut;
    assign txEligible = (req0_valid || req1_valid) && (creditReg != '0) && !lockOut;
    assign grantSel   = (req0_valid && req1_valid) ? rrPtr : req1_valid;
    assign txGrant    = (cmdSel == CMD_TX);
    assign clrEnd     = (state == ST_GAP) && (cmdReg == CMD_CLR);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        cmdSel    = CMD_NONE;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    cmdSel = CMD_CLR;
                end else if (rdEligible) begin
                    cmdSel = CMD_RD;
                end else if (txEligible) begin
                    cmdSel = CMD_TX;
                end
                if (cmdSel != CMD_NONE) begin
                    stateNext = ST_ISSUE;
                end
            end
            ST_ISSUE: stateNext = ST_GAP;
            ST_GAP:   stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cmdReg     <= CMD_NONE;
            grantReg   <= 1'b0;
            rrPtr      <= 1'b0;
            txDataReg  <= '0;
            rateReg    <= '0;
            rdDataReg  <= '0;
            rdValidReg <= 1'b0;
        end else begin
            rdValidReg <= 1'b0;
            if (state == ST_IDLE) begin
                rateReg  <= rate_sel;
                cmdReg   <= cmdSel;
                grantReg <= grantSel;
                if (txGrant) begin
                    txDataReg <= grantSel ? req1_data : req0_data;
                    rrPtr     <= ~grantSel;
                end
            end
            if (state == ST_GAP) begin
                txDataReg <= '0;
                if (cmdReg == CMD_RD) begin
                    rdDataReg  <= rx_data;
                    rdValidReg <= 1'b1;
                end
            end
        end
    end

    // Grant and return in the same cycle cancel; a clear overrides any return.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            creditReg <= CREDIT_MAX;
        end else if (clrEnd) begin
            creditReg <= CREDIT_MAX;
        end else if (txGrant && !credit_ret) begin
            creditReg <= creditReg - CW'(1);
        end else if (credit_ret && !txGrant && creditReg < CREDIT_MAX) begin
            creditReg <= creditReg + CW'(1);
        end
    end

    assign ctrl       = {((state == ST_ISSUE) ? cmdReg : CMD_NONE), rateReg};
    assign req0_ready = (state == ST_ISSUE) && (cmdReg == CMD_TX) && !grantReg;
    assign req1_ready = (state == ST_ISSUE) && (cmdReg == CMD_TX) && grantReg;
    assign tx_data    = txDataReg;
    assign rd_data    = rdDataReg;
    assign rd_valid   = rdValidReg;
    assign clr_done   = clrEnd;
    assign credits    = creditReg;

endmodule

// File: tb/tb_uart_port_sequencer.sv
// Directed bench for uart_port_sequencer: reset, TX, round-robin, credits, read, priority, async reset, error lock.
module tb_uart_port_sequencer;

    localparam int unsigned TX_DEPTH = 8;
    localparam int unsigned CW       = 4;

    logic          clk        = 1'b0;
    logic          nReset     = 1'b0;
    logic          req0_valid = 1'b0;
    logic [7:0]    req0_data  = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [7:0]    req1_data  = '0;
    logic          req1_ready;
    logic          rd_req     = 1'b0;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          clr_req    = 1'b0;
    logic          clr_done;
    logic [1:0]    rate_sel   = '0;
    logic          credit_ret = 1'b0;
    logic          uart_err   = 1'b0;
    logic [3:0]    ctrl;
    logic [7:0]    tx_data;
    logic [7:0]    rx_data    = '0;
    logic [CW-1:0] credits;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned issued;

    always #5 clk = ~clk;

    uart_port_sequencer #(
        .TX_DEPTH(TX_DEPTH),
        .CW      (CW)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .clr_req   (clr_req),
        .clr_done  (clr_done),
        .rate_sel  (rate_sel),
        .credit_ret(credit_ret),
        .uart_err  (uart_err),
        .ctrl      (ctrl),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .credits   (credits)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clearInputs;
        req0_valid = 1'b0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_data  = '0;
        rd_req     = 1'b0;
        clr_req    = 1'b0;
        rate_sel   = '0;
        credit_ret = 1'b0;
        uart_err   = 1'b0;
        rx_data    = '0;
    endtask

    // Ends on a falling edge with reset just released; the next rising edge is the first IDLE decision.
    task automatic doReset;
        nReset = 1'b0;
        clearInputs();
        tick();
        tick();
        nReset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        clearInputs();
        tick();
        tick();
        checkEq("rst_ctrl", ctrl, 4'h0);
        checkEq("rst_txdata", tx_data, 8'h00);
        checkEq("rst_rdvalid", rd_valid, 1'b0);
        checkEq("rst_rddata", rd_data, 8'h00);
        checkEq("rst_clrdone", clr_done, 1'b0);
        checkEq("rst_rdy0", req0_ready, 1'b0);
        checkEq("rst_rdy1", req1_ready, 1'b0);
        checkEq("rst_credits", credits, 8);
        nReset = 1'b1;

        // single TX from req0
        req0_valid = 1'b1;
        req0_data  = 8'hA5;
        tick();
        checkEq("tx_cmd", ctrl[3:2], 2'b01);
        checkEq("tx_data", tx_data, 8'hA5);
        checkEq("tx_rdy0", req0_ready, 1'b1);
        checkEq("tx_rdy1", req1_ready, 1'b0);
        checkEq("tx_credits", credits, 7);
        req0_valid = 1'b0;
        tick();
        checkEq("tx_gap_cmd", ctrl[3:2], 2'b00);
        checkEq("tx_gap_data", tx_data, 8'hA5);
        checkEq("tx_gap_rdy0", req0_ready, 1'b0);
        tick();
        checkEq("tx_idle_data", tx_data, 8'h00);
        checkEq("tx_idle_credits", credits, 7);

        // round-robin between two always-valid requesters
        doReset();
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        req1_valid = 1'b1;
        req1_data  = 8'h22;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkEq($sformatf("rr_cmd%0d", k), ctrl[3:2], 2'b01);
            checkEq($sformatf("rr_rdy0_%0d", k), req0_ready, (k % 2 == 0) ? 1 : 0);
            checkEq($sformatf("rr_rdy1_%0d", k), req1_ready, (k % 2 == 1) ? 1 : 0);
            checkEq($sformatf("rr_data%0d", k), tx_data, (k % 2 == 0) ? 8'h11 : 8'h22);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
            checkEq($sformatf("rr_gap%0d", k), ctrl[3:2], 2'b00);
            tick();
        end
        checkEq("rr_credits", credits, 4);

        // credit exhaustion, stall, and release by one return
        doReset();
        req0_valid = 1'b1;
        req0_data  = 8'h40;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkEq($sformatf("cr_grant%0d", k), req0_ready, 1'b1);
            tick();
            tick();
        end
        checkEq("cr_zero", credits, 0);
        issued = 0;
        repeat (6) begin
            tick();
            if (ctrl[3:2] != 2'b00 || req0_ready) issued++;
        end
        checkEq("cr_stall", issued, 0);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        checkEq("cr_ret_credits", credits, 1);
        checkEq("cr_ret_cmd", ctrl[3:2], 2'b00);
        tick();
        checkEq("cr_9th_cmd", ctrl[3:2], 2'b01);
        checkEq("cr_9th_rdy", req0_ready, 1'b1);
        checkEq("cr_9th_credits", credits, 0);
        req0_valid = 1'b0;
        tick();
        tick();

        // read with rate held across the slot
        doReset();
        rd_req   = 1'b1;
        rate_sel = 2'b10;
        tick();
        checkEq("rd_cmd", ctrl[3:2], 2'b10);
        checkEq("rd_rate_issue", ctrl[1:0], 2'b10);
        checkEq("rd_txdata", tx_data, 8'h00);
        rate_sel = 2'b01;
        rx_data  = 8'h3C;
        tick();
        checkEq("rd_gap_cmd", ctrl[3:2], 2'b00);
        checkEq("rd_rate_gap", ctrl[1:0], 2'b10);
        checkEq("rd_gap_valid", rd_valid, 1'b0);
        tick();
        checkEq("rd_valid", rd_valid, 1'b1);
        checkEq("rd_data", rd_data, 8'h3C);
        rx_data = 8'h99;
        tick();
        checkEq("rd_valid_pulse", rd_valid, 1'b0);
        checkEq("rd_data_hold", rd_data, 8'h3C);
        checkEq("rd_no_reissue", ctrl[3:2], 2'b00);
        checkEq("rd_rate_idle", ctrl[1:0], 2'b01);
        rd_req = 1'b0;
        tick();
        checkEq("rd_idle_cmd", ctrl[3:2], 2'b00);

        // priority clear > read > TX
        doReset();
        req0_valid = 1'b1;
        req0_data  = 8'h01;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        checkEq("pr_pre_credits", credits, 7);
        clr_req    = 1'b1;
        rd_req     = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        rx_data    = 8'h77;
        tick();
        checkEq("pr_clr_cmd", ctrl[3:2], 2'b11);
        checkEq("pr_clr_done_early", clr_done, 1'b0);
        checkEq("pr_clr_rdy0", req0_ready, 1'b0);
        tick();
        checkEq("pr_clr_done", clr_done, 1'b1);
        checkEq("pr_clr_gap", ctrl[3:2], 2'b00);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        clr_req    = 1'b0;
        checkEq("pr_clr_pulse", clr_done, 1'b0);
        checkEq("pr_clr_credits", credits, 8);
        tick();
        checkEq("pr_rd_cmd", ctrl[3:2], 2'b10);
        tick();
        tick();
        checkEq("pr_rd_valid", rd_valid, 1'b1);
        checkEq("pr_rd_data", rd_data, 8'h77);
        tick();
        checkEq("pr_tx_cmd", ctrl[3:2], 2'b01);
        checkEq("pr_tx_data", tx_data, 8'h5A);
        checkEq("pr_tx_rdy0", req0_ready, 1'b1);
        checkEq("pr_tx_credits", credits, 7);
        rd_req     = 1'b0;
        req0_valid = 1'b0;
        tick();
        tick();

        // asynchronous reset in the middle of a slot
        doReset();
        req0_valid = 1'b1;
        req0_data  = 8'h33;
        tick();
        checkEq("ar_cmd_before", ctrl[3:2], 2'b01);
        #2 nReset = 1'b0;
        #1;
        checkEq("ar_cmd_after", ctrl[3:2], 2'b00);
        checkEq("ar_txdata", tx_data, 8'h00);
        checkEq("ar_rdy0", req0_ready, 1'b0);
        checkEq("ar_credits", credits, 8);
        req0_valid = 1'b0;

        // uart_err handling
        doReset();
        uart_err   = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'hC3;
`ifdef UART_SEQ_ERR_LOCK_EN
        issued = 0;
        repeat (5) begin
            tick();
            if (ctrl[3:2] != 2'b00) issued++;
        end
        checkEq("lk_blocked", issued, 0);
        clr_req  = 1'b1;
        uart_err = 1'b0;
        tick();
        checkEq("lk_clr_cmd", ctrl[3:2], 2'b11);
        tick();
        checkEq("lk_clr_done", clr_done, 1'b1);
        tick();
        clr_req = 1'b0;
        tick();
        checkEq("lk_tx_cmd", ctrl[3:2], 2'b01);
        checkEq("lk_tx_data", tx_data, 8'hC3);
`else
        tick();
        checkEq("err_tx_cmd", ctrl[3:2], 2'b01);
        checkEq("err_tx_data", tx_data, 8'hC3);
        checkEq("err_tx_rdy0", req0_ready, 1'b1);
`endif
        req0_valid = 1'b0;
        uart_err   = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
